// File: rtl/sync_fifo_ex_if.sv
// Producer/consumer bundle for sync_fifo_ex: the producer side owns the requests,
// the FIFO side owns the data output and status flags.
interface sync_fifo_ex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int UW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] din;
    logic                  wr_en;
    logic                  rd_en;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  almost_full;
    logic                  empty;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
    logic [UW-1:0]         usedw;

    modport master (
        output din, wr_en, rd_en, err_clr,
        input  dout, full, almost_full, empty, almost_empty, overflow, underflow, usedw
    );

    modport slave (
        input  din, wr_en, rd_en, err_clr,
        output dout, full, almost_full, empty, almost_empty, overflow, underflow, usedw
    );
endinterface

// File: rtl/sync_fifo_ex.sv
// Single-clock FIFO with any DEPTH >= 2, registered or show-ahead read,
// and overflow/underflow reporting as pulses or sticky flags.
module sync_fifo_ex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 1,
    parameter int AE_LEVEL   = 1,
    parameter int SHOWAHEAD  = 0,
    parameter int STICKY_ERR = 0
) (
    input logic            clk,
    input logic            sclr,
    sync_fifo_ex_if.slave  bus
);
    localparam int UW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [UW-1:0] CNT_FULL = UW'(DEPTH);
    localparam logic [UW-1:0] CNT_AF   = UW'(DEPTH - AF_LEVEL);
    localparam logic [UW-1:0] CNT_AE   = UW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [UW-1:0] usedw_q, usedw_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          full_w, empty_w;
    logic          wr_acc, rd_acc, wr_rej, rd_rej;

    assign full_w  = (usedw_q == CNT_FULL);
    assign empty_w = (usedw_q == '0);

    assign wr_acc = bus.wr_en && !full_w;
    assign rd_acc = bus.rd_en && !empty_w;
    assign wr_rej = bus.wr_en && full_w;
    assign rd_rej = bus.rd_en && empty_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        // Explicit wrap compare so non-power-of-two depths work.
        if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        unique case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + 1'b1;
            2'b01:   usedw_d = usedw_q - 1'b1;
            default: usedw_d = usedw_q;
        endcase
        // A fresh error in the clear cycle keeps the sticky flag set.
        if (STICKY_ERR != 0) begin
            ovf_d = (ovf_q && !bus.err_clr) || wr_rej;
            udf_d = (udf_q && !bus.err_clr) || rd_rej;
        end else begin
            ovf_d = wr_rej;
            udf_d = rd_rej;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (!sclr && wr_acc) mem[wr_ptr_q] <= bus.din;
    end

    generate
        if (SHOWAHEAD != 0) begin : g_fwft
            assign bus.dout = mem[rd_ptr_q];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (sclr)        dout_q <= '0;
                else if (rd_acc) dout_q <= mem[rd_ptr_q];
            end
            assign bus.dout = dout_q;
        end
    endgenerate

    assign bus.usedw        = usedw_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (usedw_q >= CNT_AF);
    assign bus.almost_empty = (usedw_q <= CNT_AE);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_ex.sv
// Scoreboarded bench: instance 0 is the default registered-read FIFO with pulse errors,
// instance 1 is a DEPTH=5 show-ahead FIFO with sticky errors.
module tb_sync_fifo_ex;
    logic clk = 1'b0;
    logic sclr0, sclr1;
    always #5 clk = ~clk;

    sync_fifo_ex_if #(.DATA_WIDTH(8), .DEPTH(8)) if0 ();
    sync_fifo_ex_if #(.DATA_WIDTH(8), .DEPTH(5)) if1 ();

    sync_fifo_ex #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(1), .AE_LEVEL(1),
                   .SHOWAHEAD(0), .STICKY_ERR(0))
        dut0 (.clk(clk), .sclr(sclr0), .bus(if0));
    sync_fifo_ex #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(1), .AE_LEVEL(1),
                   .SHOWAHEAD(1), .STICKY_ERR(1))
        dut1 (.clk(clk), .sclr(sclr1), .bus(if1));

    typedef struct {
        int         k;
        logic       chk_d;
        logic [7:0] d;
        int         usedw;
        logic       full, af, empty, ae, ovf, udf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] mdout[2];
    logic       movf[2];
    logic       mudf[2];
    int         total = 0;
    int         bad   = 0;

    // Reference model: a queue of stored words plus the error/dout state.
    task automatic step(input int k);
        logic wr, rd, clr, rst, wacc, racc, sa, sticky;
        logic [7:0] d;
        int n, dep;
        exp_t e;
        if (k == 0) begin
            wr = if0.wr_en; rd = if0.rd_en; clr = if0.err_clr; rst = sclr0; d = if0.din;
            n = q0.size(); dep = 8; sa = 1'b0; sticky = 1'b0;
        end else begin
            wr = if1.wr_en; rd = if1.rd_en; clr = if1.err_clr; rst = sclr1; d = if1.din;
            n = q1.size(); dep = 5; sa = 1'b1; sticky = 1'b1;
        end
        if (rst) begin
            if (k == 0) q0.delete(); else q1.delete();
            movf[k] = 1'b0; mudf[k] = 1'b0; mdout[k] = 8'h00;
        end else begin
            wacc = wr && (n < dep);
            racc = rd && (n > 0);
            if (racc) begin
                if (k == 0) mdout[k] = q0.pop_front(); else mdout[k] = q1.pop_front();
            end
            if (wacc) begin
                if (k == 0) q0.push_back(d); else q1.push_back(d);
            end
            if (sticky) begin
                movf[k] = (movf[k] && !clr) || (wr && !wacc);
                mudf[k] = (mudf[k] && !clr) || (rd && !racc);
            end else begin
                movf[k] = wr && !wacc;
                mudf[k] = rd && !racc;
            end
        end
        n = (k == 0) ? q0.size() : q1.size();
        e.k = k; e.usedw = n;
        e.full = (n == dep); e.af = (n >= dep - 1);
        e.empty = (n == 0); e.ae = (n <= 1);
        e.ovf = movf[k]; e.udf = mudf[k];
        if (sa) begin
            e.chk_d = (n > 0);
            e.d     = (n > 0) ? q1[0] : 8'h00;
        end else begin
            e.chk_d = 1'b1;
            e.d     = mdout[k];
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        step(0);
        step(1);
        #1;
    endtask

    task automatic set0(input logic w, input logic r, input logic c, input logic [7:0] d);
        if0.wr_en = w; if0.rd_en = r; if0.err_clr = c; if0.din = d;
    endtask

    task automatic set1(input logic w, input logic r, input logic c, input logic [7:0] d);
        if1.wr_en = w; if1.rd_en = r; if1.err_clr = c; if1.din = d;
    endtask

    task automatic check(input string nm, input int k, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s[dut%0d] @%0t: got %0h, want %0h", nm, k, $time, act, want);
        end
    endtask

    // Monitor: compares every queued expectation against the instance it names.
    exp_t m;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            if (m.k == 0) begin
                check("usedw", 0, int'(if0.usedw), m.usedw);
                check("full", 0, int'(if0.full), int'(m.full));
                check("almost_full", 0, int'(if0.almost_full), int'(m.af));
                check("empty", 0, int'(if0.empty), int'(m.empty));
                check("almost_empty", 0, int'(if0.almost_empty), int'(m.ae));
                check("overflow", 0, int'(if0.overflow), int'(m.ovf));
                check("underflow", 0, int'(if0.underflow), int'(m.udf));
                if (m.chk_d) check("dout", 0, int'(if0.dout), int'(m.d));
            end else begin
                check("usedw", 1, int'(if1.usedw), m.usedw);
                check("full", 1, int'(if1.full), int'(m.full));
                check("almost_full", 1, int'(if1.almost_full), int'(m.af));
                check("empty", 1, int'(if1.empty), int'(m.empty));
                check("almost_empty", 1, int'(if1.almost_empty), int'(m.ae));
                check("overflow", 1, int'(if1.overflow), int'(m.ovf));
                check("underflow", 1, int'(if1.underflow), int'(m.udf));
                if (m.chk_d) check("dout", 1, int'(if1.dout), int'(m.d));
            end
            $display("txn dut%0d usedw=%0d dout=%02h ovf=%0b udf=%0b", m.k, m.usedw, m.d, m.ovf, m.udf);
        end
    end

    initial begin
        sclr0 = 1'b1; sclr1 = 1'b1;
        set0(1'b1, 1'b1, 1'b0, 8'hAA);
        set1(1'b1, 1'b1, 1'b0, 8'hAA);
        tick();
        sclr0 = 1'b0; sclr1 = 1'b0;
        set0(1'b0, 1'b0, 1'b0, 8'h00);
        set1(1'b0, 1'b0, 1'b0, 8'h00);
        tick();

        // Fill, overflow, drain, underflow on the registered-read instance.
        for (int i = 0; i < 9; i++) begin
            set0(1'b1, 1'b0, 1'b0, (i < 8) ? 8'(8'h10 + i) : 8'h55);
            tick();
        end
        set0(1'b0, 1'b0, 1'b0, 8'h00); tick();
        for (int i = 0; i < 9; i++) begin
            set0(1'b0, 1'b1, 1'b0, 8'h00); tick();
        end
        set0(1'b0, 1'b0, 1'b0, 8'h00); tick();

        // Steady-state simultaneous traffic at usedw=4, then rd+wr while full.
        for (int i = 0; i < 4; i++) begin set0(1'b1, 1'b0, 1'b0, 8'(8'h20 + i)); tick(); end
        for (int i = 0; i < 8; i++) begin set0(1'b1, 1'b1, 1'b0, 8'(8'hA0 + i)); tick(); end
        for (int i = 0; i < 4; i++) begin set0(1'b1, 1'b0, 1'b0, 8'(8'h30 + i)); tick(); end
        set0(1'b1, 1'b1, 1'b0, 8'hEE); tick();
        set0(1'b0, 1'b0, 1'b0, 8'h00); tick();
        for (int i = 0; i < 8; i++) begin set0(1'b0, 1'b1, 1'b0, 8'h00); tick(); end

        // Reset in the middle of a burst, then normal traffic resumes.
        for (int i = 0; i < 5; i++) begin set0(1'b1, 1'b0, 1'b0, 8'(8'h40 + i)); tick(); end
        set0(1'b1, 1'b1, 1'b0, 8'h99); sclr0 = 1'b1; tick();
        sclr0 = 1'b0;
        set0(1'b1, 1'b0, 1'b0, 8'h77); tick();
        set0(1'b0, 1'b1, 1'b0, 8'h00); tick();
        set0(1'b0, 1'b0, 1'b0, 8'h00); tick();

        // Show-ahead instance: fall-through of a single word, then wrap traffic.
        set1(1'b1, 1'b0, 1'b0, 8'h3C); tick();
        set1(1'b0, 1'b0, 1'b0, 8'h00); tick(); tick();
        set1(1'b0, 1'b1, 1'b0, 8'h00); tick();
        set1(1'b1, 1'b0, 1'b0, 8'h50); tick();
        for (int i = 0; i < 12; i++) begin set1(1'b1, 1'b1, 1'b0, 8'(8'h60 + i)); tick(); end
        set1(1'b0, 1'b1, 1'b0, 8'h00); tick();

        // Sticky underflow: hold, clear racing a new error, then a clean clear.
        set1(1'b0, 1'b1, 1'b0, 8'h00); tick();
        set1(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (5) tick();
        set1(1'b0, 1'b1, 1'b1, 8'h00); tick();
        set1(1'b0, 1'b0, 1'b1, 8'h00); tick();
        set1(1'b0, 1'b0, 1'b0, 8'h00); tick();

        // Sticky overflow from a full show-ahead FIFO.
        for (int i = 0; i < 7; i++) begin set1(1'b1, 1'b0, 1'b0, 8'(8'hB0 + i)); tick(); end
        set1(1'b0, 1'b0, 1'b0, 8'h00); tick(); tick();
        set1(1'b0, 1'b0, 1'b1, 8'h00); tick();

        // Randomised traffic on both instances, with occasional resets and clears.
        for (int i = 0; i < 600; i++) begin
            set0($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 3) == 0, 8'($urandom));
            set1($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 55,
                 $urandom_range(0, 15) == 0, 8'($urandom));
            sclr0 = ($urandom_range(0, 63) == 0);
            sclr1 = ($urandom_range(0, 63) == 0);
            tick();
        end
        sclr0 = 1'b0; sclr1 = 1'b0;
        set0(1'b0, 1'b0, 1'b0, 8'h00);
        set1(1'b0, 1'b0, 1'b0, 8'h00);
        tick();

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
